vx_stream_mux: RTL and testbench

Handshaked, optionally buffered successor to the plain select mux. It steers one of NUM_INPUTS valid/ready streams onto each of NUM_OUTPUTS independent output lanes, using a per-lane select. An optional output stage (pipe register or 2-entry skid buffer) breaks the data and ready timing paths. It sits between issue/dispatch stages and the execute units wherever a selected stream must honour back-pressure.

---
 rtl/vx_stream_mux.sv | 152 +++++++++++++++
 tb/tb_vx_stream_mux.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vx_stream_mux.sv
// Per-lane valid/ready stream selector with an optional output stage.
// OUT_BUF: 0 = combinational, 1 = pipe register, 2 = two-entry skid buffer.
module vx_stream_mux #(
  parameter int NUM_INPUTS  = 4,
  parameter int NUM_OUTPUTS = 1,
  parameter int DATAW       = 32,
  parameter int OUT_BUF     = 0,
  parameter int LN = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
  input  logic clk,
  input  logic reset,
  input  logic [NUM_OUTPUTS-1:0][LN-1:0] sel_in,
  input  logic [NUM_INPUTS-1:0][NUM_OUTPUTS-1:0] valid_in,
  input  logic [NUM_INPUTS-1:0][NUM_OUTPUTS-1:0][DATAW-1:0] data_in,
  output logic [NUM_INPUTS-1:0][NUM_OUTPUTS-1:0] ready_in,
  output logic [NUM_OUTPUTS-1:0] valid_out,
  output logic [NUM_OUTPUTS-1:0][DATAW-1:0] data_out,
  input  logic [NUM_OUTPUTS-1:0] ready_out
);

  typedef enum logic [1:0] {
    S_EMPTY,
    S_ONE,
    S_FULL
  } state_e;

  logic [NUM_OUTPUTS-1:0] sel_v;
  logic [NUM_OUTPUTS-1:0] stg_rdy;
  logic [NUM_OUTPUTS-1:0][DATAW-1:0] sel_d;

  logic unused_ok;
  assign unused_ok = ^{clk, reset};

  if (NUM_INPUTS == 1) begin : g_single
    logic [NUM_OUTPUTS*LN-1:0] unused_sel;
    assign unused_sel = sel_in;
    always_comb begin
      sel_v       = valid_in[0];
      sel_d       = data_in[0];
      ready_in[0] = stg_rdy;
    end
  end else begin : g_multi
    always_comb begin
      ready_in = '0;
      sel_v    = '0;
      sel_d    = '0;
      for (int o = 0; o < NUM_OUTPUTS; o++) begin
        sel_v[o] = valid_in[sel_in[o]][o];
        sel_d[o] = data_in[sel_in[o]][o];
        ready_in[sel_in[o]][o] = stg_rdy[o];
      end
    end
  end

  for (genvar o = 0; o < NUM_OUTPUTS; o++) begin : g_lane
    if (OUT_BUF == 0) begin : g_comb
      assign valid_out[o] = sel_v[o];
      assign data_out[o]  = sel_d[o];
      assign stg_rdy[o]   = ready_out[o];
    end else if (OUT_BUF == 1) begin : g_pipe
      logic valid_q, valid_d;
      logic [DATAW-1:0] data_q, data_d;
      logic in_fire;

      assign stg_rdy[o] = !reset && (!valid_q || ready_out[o]);
      assign in_fire    = sel_v[o] && stg_rdy[o];

      always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (in_fire) begin
          valid_d = 1'b1;
          data_d  = sel_d[o];
        end else if (ready_out[o]) begin
          valid_d = 1'b0;
        end
      end

      always_ff @(posedge clk) begin
        if (reset) valid_q <= 1'b0;
        else       valid_q <= valid_d;
        data_q <= data_d;
      end

      assign valid_out[o] = valid_q;
      assign data_out[o]  = data_q;
    end else begin : g_skid
      state_e state_q, state_d;
      logic [DATAW-1:0] out_q, out_d;
      logic [DATAW-1:0] skid_q, skid_d;
      logic in_fire, out_fire;

      // Ready comes from state only, so no path from ready_out.
      assign stg_rdy[o] = !reset && (state_q != S_FULL);
      assign in_fire    = sel_v[o] && stg_rdy[o];
      assign out_fire   = (state_q != S_EMPTY) && ready_out[o];

      always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        unique case (state_q)
          S_EMPTY: begin
            if (in_fire) begin
              state_d = S_ONE;
              out_d   = sel_d[o];
            end
          end
          S_ONE: begin
            if (in_fire && out_fire) begin
              out_d = sel_d[o];
            end else if (in_fire) begin
              state_d = S_FULL;
              skid_d  = sel_d[o];
            end else if (out_fire) begin
              state_d = S_EMPTY;
            end
          end
          S_FULL: begin
            if (out_fire) begin
              state_d = S_ONE;
              out_d   = skid_q;
            end
          end
          default: state_d = S_EMPTY;
        endcase
      end

      always_ff @(posedge clk) begin
        if (reset) state_q <= S_EMPTY;
        else       state_q <= state_d;
        out_q  <= out_d;
        skid_q <= skid_d;
      end

      assign valid_out[o] = (state_q != S_EMPTY);
      assign data_out[o]  = out_q;
    end

    if (NUM_INPUTS > 1) begin : g_sel_chk
      a_sel: assert property (@(posedge clk) disable iff (reset)
        int'(sel_in[o]) < NUM_INPUTS);
    end

    if (OUT_BUF != 0) begin : g_hold_chk
      a_hold: assert property (@(posedge clk) disable iff (reset)
        valid_out[o] && !ready_out[o]
        |=> valid_out[o] && $stable(data_out[o]));
    end
  end

endmodule

// File: tb/tb_vx_stream_mux.sv
// Bench for vx_stream_mux: three instances (modes 0/1/2, two lanes each)
// checked every cycle against a queue model, plus directed scenarios.
module tb_vx_stream_mux;
  localparam int NI = 4;
  localparam int NO = 2;
  localparam int DW = 32;
  localparam int LN = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst [3];
  logic [NO-1:0][LN-1:0] sel [3];
  logic [NI-1:0][NO-1:0] vin [3];
  logic [NI-1:0][NO-1:0][DW-1:0] din [3];
  logic [NI-1:0][NO-1:0] rin [3];
  logic [NO-1:0] vo [3];
  logic [NO-1:0] ro [3];
  logic [NO-1:0][DW-1:0] dout [3];

  vx_stream_mux #(.NUM_INPUTS(NI), .NUM_OUTPUTS(NO),
    .DATAW(DW), .OUT_BUF(0)) u0 (
    .clk(clk), .reset(rst[0]), .sel_in(sel[0]),
    .valid_in(vin[0]), .data_in(din[0]), .ready_in(rin[0]),
    .valid_out(vo[0]), .data_out(dout[0]), .ready_out(ro[0]));

  vx_stream_mux #(.NUM_INPUTS(NI), .NUM_OUTPUTS(NO),
    .DATAW(DW), .OUT_BUF(1)) u1 (
    .clk(clk), .reset(rst[1]), .sel_in(sel[1]),
    .valid_in(vin[1]), .data_in(din[1]), .ready_in(rin[1]),
    .valid_out(vo[1]), .data_out(dout[1]), .ready_out(ro[1]));

  vx_stream_mux #(.NUM_INPUTS(NI), .NUM_OUTPUTS(NO),
    .DATAW(DW), .OUT_BUF(2)) u2 (
    .clk(clk), .reset(rst[2]), .sel_in(sel[2]),
    .valid_in(vin[2]), .data_in(din[2]), .ready_in(rin[2]),
    .valid_out(vo[2]), .data_out(dout[2]), .ready_out(ro[2]));

  int n_cmp = 0;
  int n_bad = 0;
  logic [DW-1:0] mq [3*NO][$];
  logic [DW-1:0] got [$];

  task automatic chk(input string nm, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Model: mode 0 is a pure mux; modes 1/2 are FIFOs of depth 1/2.
  task automatic model_lane(input int k, input int o);
    int s, idx;
    logic v;
    logic [DW-1:0] d, ed;
    bit sr, ev;
    s   = int'(sel[k][o]);
    v   = vin[k][s][o];
    d   = din[k][s][o];
    idx = k * NO + o;
    if (k == 0) begin
      ev = v; ed = d; sr = ro[k][o];
    end else begin
      ev = (mq[idx].size() != 0);
      ed = ev ? mq[idx][0] : '0;
      if (k == 1)
        sr = !rst[k] && (mq[idx].size() == 0 || ro[k][o]);
      else
        sr = !rst[k] && (mq[idx].size() < 2);
    end
    for (int i = 0; i < NI; i++)
      chk($sformatf("u%0d.l%0d.ready_in%0d", k, o, i),
          DW'(rin[k][i][o]), DW'((i == s) && sr));
    chk($sformatf("u%0d.l%0d.valid_out", k, o),
        DW'(vo[k][o]), DW'(ev));
    if (ev)
      chk($sformatf("u%0d.l%0d.data_out", k, o), dout[k][o], ed);
    if (k != 0) begin
      if (rst[k]) begin
        mq[idx].delete();
      end else begin
        if (ev && ro[k][o]) void'(mq[idx].pop_front());
        if (v && sr) mq[idx].push_back(d);
      end
    end
  endtask

  task automatic tick();
    for (int k = 0; k < 3; k++)
      for (int o = 0; o < NO; o++)
        model_lane(k, o);
    @(negedge clk);
  endtask

  task automatic clr(input int k);
    vin[k] = '0; ro[k] = '0; rst[k] = 1'b0; sel[k] = '0;
  endtask

  logic [3:0] col;
  logic [DW-1:0] nxt, n0, n1, n3;
  logic acc, a0, a1, a3;
  logic [DW-1:0] exp4 [4];

  initial begin
    for (int k = 0; k < 3; k++) begin
      clr(k); din[k] = '0; rst[k] = 1'b1;
    end
    @(negedge clk);
    #2;
    chk("rst.u1.ready_all", DW'(rin[1]), '0);
    chk("rst.u2.ready_all", DW'(rin[2]), '0);
    tick();
    for (int k = 0; k < 3; k++) rst[k] = 1'b0;
    #2;
    chk("post_rst.u2.valid", DW'(vo[2]), '0);
    chk("post_rst.u2.ready0", DW'(rin[2][0][0]), 1);
    chk("post_rst.u1.ready0", DW'(rin[1][0][0]), 1);
    tick();

    // Mode 0 steering
    sel[0][0] = 2'd2; ro[0] = '1;
    for (int i = 0; i < NI; i++) begin
      vin[0][i][0] = 1'b1; din[0][i][0] = DW'(32'hA0 + i);
    end
    #2;
    col = {rin[0][3][0], rin[0][2][0], rin[0][1][0], rin[0][0][0]};
    chk("m0.sel2.data", dout[0][0], 32'hA2);
    chk("m0.sel2.ready", DW'(col), 4'b0100);
    tick();
    sel[0][0] = 2'd0;
    #2;
    col = {rin[0][3][0], rin[0][2][0], rin[0][1][0], rin[0][0][0]};
    chk("m0.sel0.data", dout[0][0], 32'hA0);
    chk("m0.sel0.ready", DW'(col), 4'b0001);
    tick();
    clr(0);

    // Mode 1 back-pressure: beats 1..5, ready_out low in cycles 3-4
    nxt = 1; got.delete();
    for (int c = 1; c <= 10; c++) begin
      sel[1][0] = 2'd1;
      vin[1][1][0] = (nxt <= 5); din[1][1][0] = nxt;
      ro[1][0] = !(c == 3 || c == 4);
      #2;
      if (c == 3) chk("m1.stall.ready", DW'(rin[1][1][0]), 0);
      if (vo[1][0] && ro[1][0]) got.push_back(dout[1][0]);
      acc = rin[1][1][0] && vin[1][1][0];
      tick();
      if (acc) nxt++;
    end
    chk("m1.count", DW'(got.size()), 5);
    for (int i = 0; i < got.size() && i < 5; i++)
      chk($sformatf("m1.seq%0d", i), got[i], DW'(i + 1));
    clr(1);

    // Mode 2 skid: ready_out low for cycles 3-5
    nxt = 32'h10; got.delete();
    for (int c = 1; c <= 16; c++) begin
      sel[2][0] = 2'd1;
      vin[2][1][0] = (nxt < 32'h1A); din[2][1][0] = nxt;
      ro[2][0] = !(c >= 3 && c <= 5);
      #2;
      if (c >= 3 && c <= 7)
        chk($sformatf("m2.skid.ready.c%0d", c),
            DW'(rin[2][1][0]), DW'(c == 3 || c == 7));
      if (vo[2][0] && ro[2][0]) got.push_back(dout[2][0]);
      acc = rin[2][1][0] && vin[2][1][0];
      tick();
      if (acc) nxt++;
    end
    chk("m2.skid.count", DW'(got.size()), 10);
    for (int i = 0; i < got.size() && i < 10; i++)
      chk($sformatf("m2.skid.seq%0d", i), got[i], DW'(32'h10 + i));
    clr(2);

    // Mode 2 select change while FULL
    n1 = 32'h20; n3 = 32'h30; got.delete();
    for (int c = 1; c <= 10; c++) begin
      sel[2][0] = (c >= 3) ? 2'd3 : 2'd1;
      vin[2][1][0] = 1'b1; din[2][1][0] = n1;
      vin[2][3][0] = (n3 < 32'h32); din[2][3][0] = n3;
      ro[2][0] = (c >= 3);
      #2;
      if (c >= 3) chk($sformatf("m2.swap.in1_ready.c%0d", c),
                      DW'(rin[2][1][0]), 0);
      if (vo[2][0] && ro[2][0]) got.push_back(dout[2][0]);
      a1 = rin[2][1][0] && vin[2][1][0];
      a3 = rin[2][3][0] && vin[2][3][0];
      tick();
      if (a1) n1++;
      if (a3) n3++;
    end
    exp4 = '{32'h20, 32'h21, 32'h30, 32'h31};
    chk("m2.swap.count", DW'(got.size()), 4);
    for (int i = 0; i < got.size() && i < 4; i++)
      chk($sformatf("m2.swap.seq%0d", i), got[i], exp4[i]);
    clr(2);

    // Mode 2 reset while FULL
    for (int c = 1; c <= 7; c++) begin
      sel[2][0] = 2'd0;
      rst[2] = (c == 3);
      vin[2][0][0] = (c <= 3); din[2][0][0] = DW'(32'h40 + c - 1);
      ro[2][0] = (c >= 4);
      #2;
      if (c == 3) chk("m2.rst.ready_all", DW'(rin[2]), '0);
      if (c == 4) chk("m2.rst.ready_after", DW'(rin[2][0][0]), 1);
      if (c >= 4) chk($sformatf("m2.rst.valid.c%0d", c),
                      DW'(vo[2][0]), 0);
      tick();
    end
    clr(2);

    // Two lanes: lane 0 streaming, lane 1 stalled
    n0 = 32'h50; n1 = 32'h60;
    for (int c = 1; c <= 8; c++) begin
      sel[2][0] = 2'd2; sel[2][1] = 2'd0;
      vin[2][2][0] = 1'b1; din[2][2][0] = n0;
      vin[2][0][1] = 1'b1; din[2][0][1] = n1;
      ro[2] = 2'b01;
      #2;
      if (c >= 2) begin
        chk($sformatf("lanes.l0.valid.c%0d", c), DW'(vo[2][0]), 1);
        chk($sformatf("lanes.l0.data.c%0d", c), dout[2][0],
            DW'(32'h50 + c - 2));
        chk($sformatf("lanes.l1.valid.c%0d", c), DW'(vo[2][1]), 1);
        chk($sformatf("lanes.l1.data.c%0d", c), dout[2][1], 32'h60);
      end
      a0 = rin[2][2][0];
      a1 = rin[2][0][1];
      tick();
      if (a0) n0++;
      if (a1) n1++;
    end
    clr(2);

    // Random traffic on all instances
    for (int c = 0; c < 1500; c++) begin
      for (int k = 0; k < 3; k++) begin
        rst[k] = (k != 0) && ($urandom_range(63) == 0);
        for (int o = 0; o < NO; o++) begin
          sel[k][o] = LN'($urandom_range(NI - 1));
          ro[k][o]  = ($urandom_range(3) != 0);
          for (int i = 0; i < NI; i++) begin
            vin[k][i][o] = 1'($urandom_range(1));
            din[k][i][o] = $urandom;
          end
        end
      end
      #2;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
